// File: rtl/mdu_sched.sv
// Multiply/divide unit scheduler: sequences busy/done timing and generates pipeline stalls.
// Define MDU_SCHED_PERF_EN to add the cumulative stall-cycle counter on stall_cnt.
module mdu_sched #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        E_start,
   input  logic [1:0]  E_op,
   input  logic        D_hilo_use,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [3:0]  cnt,
   output logic        mdu_stall,
   output logic        F_enable,
   output logic        D_enable,
   output logic        E_flush,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state;
   logic [3:0] load_cnt;

   assign load_cnt = E_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

   // busy and done are registered alongside the state so they are clean Moore outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (cancel) begin
         state <= IDLE;
         cnt   <= 4'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (E_start) begin
                  state <= RUN;
                  cnt   <= load_cnt;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (cnt <= 4'd1) begin
                  state <= DONE;
                  cnt   <= 4'd0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               done <= 1'b0;
               if (E_start) begin
                  state <= RUN;
                  cnt   <= load_cnt;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  cnt   <= 4'd0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 4'd0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // A HI/LO consumer in D waits while an operation is issuing or running, never during reset
   assign mdu_stall = ~reset & D_hilo_use & (E_start | busy);
   assign F_enable  = ~mdu_stall;
   assign D_enable  = ~mdu_stall;
   assign E_flush   = mdu_stall;

`ifdef MDU_SCHED_PERF_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_q <= 32'd0;
      else if (mdu_stall)
         stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed scenarios then random traffic against a
// timeline model (each accepted operation predicts its busy window and done cycle).
module tb_mdu_sched;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        E_start;
   logic [1:0]  E_op;
   logic        D_hilo_use;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [3:0]  cnt;
   logic        mdu_stall;
   logic        F_enable;
   logic        D_enable;
   logic        E_flush;
   logic [31:0] stall_cnt;

   int          vectors = 0;
   int          miscompares = 0;

   int          cyc = 0;
   bit          active = 0;
   int          startAt = 0;
   int          doneAt = 0;
   logic [31:0] stallCount = 32'd0;

   mdu_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .E_start(E_start), .E_op(E_op),
      .D_hilo_use(D_hilo_use), .cancel(cancel), .busy(busy), .done(done),
      .cnt(cnt), .mdu_stall(mdu_stall), .F_enable(F_enable), .D_enable(D_enable),
      .E_flush(E_flush), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] expStallCnt();
`ifdef MDU_SCHED_PERF_EN
      return stallCount;
`else
      return 32'd0;
`endif
   endfunction

   function automatic bit modelBusy();
      return active && (cyc > startAt) && (cyc < doneAt);
   endfunction

   function automatic bit modelStall();
      return D_hilo_use && (E_start || modelBusy());
   endfunction

   task automatic checkOutput();
      bit expBusy;
      bit expStall;
      expBusy  = modelBusy();
      expStall = modelStall();
      checkOne("busy", 32'(busy), 32'(expBusy));
      checkOne("done", 32'(done), 32'(active && cyc == doneAt));
      checkOne("cnt", 32'(cnt), expBusy ? 32'(doneAt - cyc) : 32'd0);
      checkOne("mdu_stall", 32'(mdu_stall), 32'(expStall));
      checkOne("F_enable", 32'(F_enable), 32'(!expStall));
      checkOne("D_enable", 32'(D_enable), 32'(!expStall));
      checkOne("E_flush", 32'(E_flush), 32'(expStall));
      checkOne("stall_cnt", stall_cnt, expStallCnt());
   endtask

   // Advance the timeline model across one clock edge using the inputs just applied
   task automatic modelStep();
      bit wasBusy;
      wasBusy = modelBusy();
      if (modelStall()) stallCount = stallCount + 32'd1;
      if (cancel) begin
         active = 0;
      end else if (E_start && !wasBusy) begin
         active  = 1;
         startAt = cyc;
         doneAt  = cyc + (E_op[1] ? DIV_N : MULT_N) + 1;
      end else if (active && cyc >= doneAt) begin
         active = 0;
      end
      cyc++;
   endtask

   task automatic applyStimulus(input logic s, input logic [1:0] op, input logic h, input logic c);
      E_start    = s;
      E_op       = op;
      D_hilo_use = h;
      cancel     = c;
      #2;
      checkOutput();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic idle(input int n, input logic h);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, h, 1'b0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOne({tag, "_busy"}, 32'(busy), 32'd0);
      checkOne({tag, "_done"}, 32'(done), 32'd0);
      checkOne({tag, "_cnt"}, 32'(cnt), 32'd0);
      checkOne({tag, "_stall"}, 32'(mdu_stall), 32'd0);
      checkOne({tag, "_F_enable"}, 32'(F_enable), 32'd1);
      checkOne({tag, "_D_enable"}, 32'(D_enable), 32'd1);
      checkOne({tag, "_E_flush"}, 32'(E_flush), 32'd0);
      checkOne({tag, "_stall_cnt"}, stall_cnt, 32'd0);
   endtask

   // Pulse reset between edges with stall-provoking inputs present
   task automatic asyncReset();
      E_start    = 1'b1;
      D_hilo_use = 1'b1;
      cancel     = 1'b0;
      reset      = 1'b1;
      #1;
      checkResetOutputs("async_reset");
      #1;
      reset      = 1'b0;
      E_start    = 1'b0;
      D_hilo_use = 1'b0;
      active     = 0;
      stallCount = 32'd0;
   endtask

   initial begin
      reset      = 1'b1;
      E_start    = 1'b1;
      E_op       = 2'b10;
      D_hilo_use = 1'b1;
      cancel     = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkResetOutputs("reset");
      reset   = 1'b0;
      E_start = 1'b0;
      #1;

      $display("[TB] mult latency");
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      idle(7, 1'b0);

      $display("[TB] div with waiting HI/LO consumer");
      applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
      idle(11, 1'b1);
      idle(2, 1'b0);

      $display("[TB] div cancelled mid-run");
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      idle(3, 1'b1);
      applyStimulus(1'b1, 2'b00, 1'b1, 1'b1);
      idle(12, 1'b0);

      $display("[TB] back-to-back mult then multu");
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      idle(5, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
      idle(7, 1'b0);

      $display("[TB] start ignored while running");
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b11, 1'b1, 1'b0);
      idle(5, 1'b0);

      $display("[TB] async reset mid-run");
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      idle(2, 1'b0);
      asyncReset();
      idle(8, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                       2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
      end
      idle(12, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
